// File: rtl/signed_pipelined_fixed_point_addsub.sv
`default_nettype none
// ============================================================================
// Module      : signed_pipelined_fixed_point_addsub
// Description : Segmented-carry pipelined signed add/sub, one SEG-bit slice
//               per stage, valid/ready handshake, saturation and overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module signed_pipelined_fixed_point_addsub #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   Sum,
    output logic [WIDTH-1:0] Y,
    output logic             overflow
);
    localparam int STAGES = WIDTH / SEG;
    localparam int C_MID  = STAGES - 1;  // number of internal pipeline registers

    logic             w_adv;
    logic [WIDTH:0]   w_a0;
    logic [WIDTH:0]   w_b0;
    logic [SEG:0]     w_s    [C_MID];
    logic [WIDTH:0]   w_nacc [C_MID];
    logic [SEG:0]     w_top;
    logic [WIDTH:0]   w_sum;
    logic             w_ovf;
    logic [WIDTH-1:0] w_y;
    logic             w_unused;

    // r_acc holds finished low result bits with the still-unprocessed A bits above
    logic [WIDTH:0]   r_acc  [C_MID];
    logic [WIDTH:0]   r_b    [C_MID];
    logic             r_c    [C_MID];
    logic             r_sat  [C_MID];
    logic             r_v    [C_MID];
    logic             r_out_valid;
    logic [WIDTH:0]   r_sum;
    logic [WIDTH-1:0] r_y;
    logic             r_ovf;

    assign w_adv    = !r_out_valid || out_ready;
    assign in_ready = rst && w_adv;

    assign w_a0 = {A[WIDTH-1], A};
    assign w_b0 = {B[WIDTH-1], B} ^ {(WIDTH+1){sub}};

    always_comb begin
        w_s[0]    = {1'b0, w_a0[SEG-1:0]} + {1'b0, w_b0[SEG-1:0]} + {{SEG{1'b0}}, sub};
        w_nacc[0] = {w_a0[WIDTH:SEG], w_s[0][SEG-1:0]};
        for (int k = 1; k < C_MID; k++) begin
            w_s[k]    = {1'b0, r_acc[k-1][k*SEG +: SEG]} + {1'b0, r_b[k-1][k*SEG +: SEG]}
                      + {{SEG{1'b0}}, r_c[k-1]};
            w_nacc[k] = r_acc[k-1];
            w_nacc[k][k*SEG +: SEG] = w_s[k][SEG-1:0];
        end
    end

    // Top slice is SEG+1 bits wide because the operands were sign-extended
    assign w_top = r_acc[C_MID-1][WIDTH -: SEG+1] + r_b[C_MID-1][WIDTH -: SEG+1]
                 + {{SEG{1'b0}}, r_c[C_MID-1]};
    assign w_sum = {w_top, r_acc[C_MID-1][WIDTH-SEG-1:0]};
    assign w_ovf = w_sum[WIDTH] ^ w_sum[WIDTH-1];
    assign w_y   = (w_ovf && r_sat[C_MID-1])
                 ? (w_sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
                 : w_sum[WIDTH-1:0];

    assign w_unused = ^r_b[C_MID-1][WIDTH-SEG-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < C_MID; k++) begin
                r_acc[k] <= '0;
                r_b[k]   <= '0;
                r_c[k]   <= 1'b0;
                r_sat[k] <= 1'b0;
                r_v[k]   <= 1'b0;
            end
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_y         <= '0;
            r_ovf       <= 1'b0;
        end else if (w_adv) begin
            r_v[0]   <= in_valid;
            r_acc[0] <= w_nacc[0];
            r_b[0]   <= w_b0;
            r_c[0]   <= w_s[0][SEG];
            r_sat[0] <= sat;
            for (int k = 1; k < C_MID; k++) begin
                r_v[k]   <= r_v[k-1];
                r_acc[k] <= w_nacc[k];
                r_b[k]   <= r_b[k-1];
                r_c[k]   <= w_s[k][SEG];
                r_sat[k] <= r_sat[k-1];
            end
            r_out_valid <= r_v[C_MID-1];
            if (r_v[C_MID-1]) begin
                r_sum <= w_sum;
                r_y   <= w_y;
                r_ovf <= w_ovf;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign Sum       = r_sum;
    assign Y         = r_y;
    assign overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_signed_pipelined_fixed_point_addsub.sv
`default_nettype none
// ============================================================================
// Module      : tb_signed_pipelined_fixed_point_addsub
// Description : Directed and streaming checks for the pipelined add/sub.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_signed_pipelined_fixed_point_addsub;
    localparam int WIDTH  = 16;
    localparam int SEG    = 4;
    localparam int STAGES = WIDTH / SEG;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  A;
    logic [WIDTH-1:0]  B;
    logic              sub;
    logic              sat;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH:0]    Sum;
    logic [WIDTH-1:0]  Y;
    logic              overflow;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    signed_pipelined_fixed_point_addsub #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .sub(sub), .sat(sat),
        .out_valid(out_valid), .out_ready(out_ready),
        .Sum(Sum), .Y(Y), .overflow(overflow)
    );

    // Drive one transaction into an idle pipeline and wait (bounded) for its result
    task automatic send_one(input logic [15:0] a, input logic [15:0] b, input logic s,
                            input logic t, output int lat, output logic [16:0] so,
                            output logic [15:0] yo, output logic oo);
        @(negedge clk);
        A = a; B = b; sub = s; sat = t; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        so = Sum; yo = Y; oo = overflow;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        A = 16'h1234; B = 16'h4321; sub = 1'b0; sat = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_ready: got %b, need 0", in_ready);
        end
        n_tests++;
        if (out_valid !== 1'b0 || Sum !== 17'h0 || Y !== 16'h0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b Sum=%h Y=%h ovf=%b, need 0 0 0 0",
                     out_valid, Sum, Y, overflow);
        end
        in_valid = 1'b0; out_ready = 1'b1; rst = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL ready_after_reset: got %b, need 1", in_ready);
        end
    endtask

    task automatic test_carry_chain();
        int lat; logic [16:0] so; logic [15:0] yo; logic oo;
        send_one(16'h0FFF, 16'h0001, 1'b0, 1'b0, lat, so, yo, oo);
        n_tests++;
        if (lat !== STAGES) begin
            n_fail++; $display("FAIL carry_latency: got %0d, need %0d", lat, STAGES);
        end
        n_tests++;
        if (so !== 17'h01000 || yo !== 16'h1000 || oo !== 1'b0) begin
            n_fail++;
            $display("FAIL carry_result: got Sum=%h Y=%h ovf=%b, need 01000 1000 0", so, yo, oo);
        end
    endtask

    task automatic test_pos_overflow();
        int lat; logic [16:0] so; logic [15:0] yo; logic oo;
        send_one(16'h7FFF, 16'h0001, 1'b0, 1'b1, lat, so, yo, oo);
        n_tests++;
        if (so !== 17'h08000 || yo !== 16'h7FFF || oo !== 1'b1) begin
            n_fail++;
            $display("FAIL pos_ovf_sat: got Sum=%h Y=%h ovf=%b, need 08000 7fff 1", so, yo, oo);
        end
        send_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat, so, yo, oo);
        n_tests++;
        if (so !== 17'h08000 || yo !== 16'h8000 || oo !== 1'b1) begin
            n_fail++;
            $display("FAIL pos_ovf_wrap: got Sum=%h Y=%h ovf=%b, need 08000 8000 1", so, yo, oo);
        end
    endtask

    task automatic test_neg_sub_overflow();
        int lat; logic [16:0] so; logic [15:0] yo; logic oo;
        send_one(16'h8000, 16'h0001, 1'b1, 1'b1, lat, so, yo, oo);
        n_tests++;
        if (so !== 17'h17FFF || yo !== 16'h8000 || oo !== 1'b1) begin
            n_fail++;
            $display("FAIL neg_ovf_sat: got Sum=%h Y=%h ovf=%b, need 17fff 8000 1", so, yo, oo);
        end
        send_one(16'h8000, 16'h0001, 1'b1, 1'b0, lat, so, yo, oo);
        n_tests++;
        if (so !== 17'h17FFF || yo !== 16'h7FFF || oo !== 1'b1) begin
            n_fail++;
            $display("FAIL neg_ovf_wrap: got Sum=%h Y=%h ovf=%b, need 17fff 7fff 1", so, yo, oo);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1; A = 16'hFFFF; B = 16'hFFFF; sub = 1'b0; sat = 1'b0;
        @(negedge clk);
        A = 16'h0005; B = 16'h0007; sub = 1'b1; sat = 1'b0;
        @(negedge clk);
        A = 16'h0005; B = 16'h0007; sub = 1'b1; sat = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b1 || Sum !== 17'h1FFFE || Y !== 16'hFFFE || overflow !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_%0d: got v=%b Sum=%h Y=%h ovf=%b, need 1 1fffe fffe 0",
                         i, out_valid, Sum, Y, overflow);
            end
        end
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_drain: got out_valid=%b, need 0", out_valid);
        end
    endtask

    task automatic test_stream_backpressure();
        logic [16:0] q_sum[$];
        logic [15:0] q_y[$];
        logic        q_ovf[$];
        logic [15:0] ca, cb;
        logic        cs, ct, stalled, ho, eo, er;
        logic [16:0] hs;
        logic [15:0] hy, ey;
        logic signed [16:0] ea, eb, es;
        int sent, got, cyc;
        sent = 0; got = 0; cyc = 0; stalled = 1'b0;
        hs = '0; hy = '0; ho = 1'b0;
        ca = 16'($urandom); cb = 16'($urandom); cs = 1'($urandom); ct = 1'($urandom);
        while (got < 20 && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (stalled) begin
                n_tests++;
                if (out_valid !== 1'b1 || Sum !== hs || Y !== hy || overflow !== ho) begin
                    n_fail++;
                    $display("FAIL stall_hold: got v=%b Sum=%h Y=%h ovf=%b, need 1 %h %h %b",
                             out_valid, Sum, Y, overflow, hs, hy, ho);
                end
            end
            out_ready = ($urandom_range(0, 2) != 0);
            if (sent < 20) begin
                in_valid = 1'b1; A = ca; B = cb; sub = cs; sat = ct;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            er = !(out_valid && !out_ready);
            n_tests++;
            if (in_ready !== er) begin
                n_fail++; $display("FAIL stream_in_ready: got %b, need %b", in_ready, er);
            end
            if (out_valid === 1'b1 && out_ready) begin
                n_tests++;
                if (q_sum.size() == 0) begin
                    n_fail++; $display("FAIL stream_extra: got Sum=%h, need no result", Sum);
                end else begin
                    if (Sum !== q_sum[0] || Y !== q_y[0] || overflow !== q_ovf[0]) begin
                        n_fail++;
                        $display("FAIL stream_%0d: got Sum=%h Y=%h ovf=%b, need %h %h %b",
                                 got, Sum, Y, overflow, q_sum[0], q_y[0], q_ovf[0]);
                    end
                    void'(q_sum.pop_front()); void'(q_y.pop_front()); void'(q_ovf.pop_front());
                end
                got++;
            end
            stalled = (out_valid === 1'b1) && !out_ready;
            hs = Sum; hy = Y; ho = overflow;
            if (in_valid && in_ready === 1'b1) begin
                ea = {ca[15], ca};
                eb = {cb[15], cb};
                es = cs ? ea - eb : ea + eb;
                eo = es[16] ^ es[15];
                ey = (eo && ct) ? (es[16] ? 16'h8000 : 16'h7FFF) : es[15:0];
                q_sum.push_back(es); q_y.push_back(ey); q_ovf.push_back(eo);
                sent++;
                ca = 16'($urandom); cb = 16'($urandom); cs = 1'($urandom); ct = 1'($urandom);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_tests++;
        if (got != 20 || sent != 20 || q_sum.size() != 0) begin
            n_fail++;
            $display("FAIL stream_count: got %0d sent %0d left %0d, need 20 20 0",
                     got, sent, q_sum.size());
        end
        repeat (STAGES + 1) @(negedge clk);
    endtask

    task automatic test_reset_midstream();
        int lat; logic [16:0] so; logic [15:0] yo; logic oo;
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; sub = 1'b0; sat = 1'b0;
        A = 16'h1111; B = 16'h2222;
        @(negedge clk);
        A = 16'h3333; B = 16'h4444;
        @(negedge clk);
        A = 16'h0100; B = 16'h0001; sub = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_clear: got out_valid=%b in_ready=%b, need 0 0",
                     out_valid, in_ready);
        end
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_ghost_%0d: got out_valid=%b Sum=%h, need 0", i, out_valid, Sum);
            end
        end
        send_one(16'h1234, 16'h0F0F, 1'b1, 1'b0, lat, so, yo, oo);
        n_tests++;
        if (lat !== STAGES || so !== 17'h00325 || yo !== 16'h0325 || oo !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset: got lat=%0d Sum=%h Y=%h ovf=%b, need %0d 00325 0325 0",
                     lat, so, yo, oo, STAGES);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_carry_chain();
        test_pos_overflow();
        test_neg_sub_overflow();
        test_back_to_back();
        test_stream_backpressure();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/signed_pipelined_fixed_point_addsub.md
# signed_pipelined_fixed_point_addsub

Parametrised, segmented-carry pipelined signed fixed-point adder/subtractor with a valid/ready handshake, per-transaction saturation and an overflow flag. Each pipeline stage adds one SEG-bit slice of the operands and registers the carry into the next stage, so the carry path per cycle is one slice long. This is the general-purpose successor to the fixed 8-bit two-stage adder in the HW datapath. Accumulators and filters use it wherever they need a width-scalable add/sub with a fixed, known latency.

## Interface
- WIDTH, 16, operand width in bits, two's complement. The binary point position is irrelevant to the block.
- SEG, 4, slice width per stage. WIDTH % SEG == 0 is required.
- STAGES, WIDTH/SEG, derived (localparam). It is the latency in cycles and must be >= 2.

- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-low
- in_valid  input  1  A, B, sub, sat are valid this cycle
- in_ready  output  1  block accepts the input this cycle
- A  input  WIDTH  signed operand A
- B  input  WIDTH  signed operand B
- sub  input  1  0: A+B, 1: A-B
- sat  input  1  1: Y saturates on overflow, 0: Y wraps
- out_valid  output  1  result outputs are valid
- out_ready  input  1  downstream accepts the result
- Sum  output  WIDTH+1  exact signed result, never overflows
- Y  output  WIDTH  WIDTH-bit result, saturated or wrapped per the sat flag of that transaction
- overflow  output  1  the exact result is not representable in WIDTH bits

## Operation
- The B operand is effectively B when sub=0 and ~B when sub=1. The carry-in to slice 0 equals sub.
- Operands are sign-extended to WIDTH+1 bits. The top slice therefore produces SEG+1 result bits, and Sum is the exact result.
- Stage k (0..STAGES-1) adds slice k of A and of the effective B, plus the registered carry from stage k-1. It passes the following to stage k+1:
  - lower result bits so far
  - unprocessed upper operand bits
  - carry
  - sub and sat flags
  - a valid bit
- Stage 0 captures the input when in_valid && in_ready.
- overflow = Sum[WIDTH] XOR Sum[WIDTH-1].
- Y:
  - If overflow && sat: Y = 0x7F..F when Sum[WIDTH]=0, and Y = 0x80..0 when Sum[WIDTH]=1.
  - Otherwise: Y = Sum[WIDTH-1:0].
- The sub and sat flags travel with their own transaction. Mixing modes back-to-back is legal.
- There is no internal state other than the pipeline registers, and no FSM. Control is one advance signal: adv = !out_valid || out_ready.

## Timing
- Reset (rst=0 at a rising edge):
  - All stage valid bits clear to 0.
  - out_valid=0, Sum=0, Y=0, overflow=0.
  - Data registers clear to 0.
  - Transactions in flight are discarded.
  - in_ready is 0 while rst=0.
- in_ready = adv, a combinational function of out_valid and out_ready. When rst=1 it does not depend on in_valid.
- Latency: a transaction accepted at edge n appears with out_valid=1 after edge n+STAGES-1, i.e. STAGES cycles from acceptance to being presented, assuming no stall.
- Throughput: one transaction per cycle while out_ready=1.
- Stall: when out_valid && !out_ready, every stage holds, in_ready=0, and Sum, Y and overflow stay stable. Inputs presented in that cycle are not captured; the source must hold them.
- Bubbles (in_valid=0) propagate as invalid slots. They are not collapsed.
- The outputs Sum, Y, overflow and out_valid are registered, not combinational from the inputs.
- Reset has priority over stall and advance in the same cycle.

## Test plan
- Reset, then one transaction: WIDTH=16, SEG=4.
  - Stimulus: A=0x0FFF, B=0x0001, sub=0, out_ready=1.
  - Required: exactly 4 cycles later out_valid=1, Sum=0x01000, Y=0x1000, overflow=0. This exercises the carry crossing three slices.
- Positive overflow.
  - Stimulus: A=0x7FFF, B=0x0001, sub=0, sat=1.
  - Required: Sum=0x08000, overflow=1, Y=0x7FFF. With sat=0 the same operands give Y=0x8000.
- Negative subtract overflow.
  - Stimulus: A=0x8000, B=0x0001, sub=1, sat=1.
  - Required: Sum=0x17FFF, overflow=1, Y=0x8000.
- Negatives without overflow, then a mode mix.
  - Stimulus: A=0xFFFF+B=0xFFFF (sub=0), then back-to-back 0x0005-0x0007 (sub=1).
  - Required: Sum=0x1FFFE with Y=0xFFFE and overflow=0, then Y=0xFFFE on consecutive cycles.
- Streaming with backpressure.
  - Stimulus: 20 random transactions in back-to-back cycles, out_ready toggled pseudo-randomly.
  - Required: results in order and matching the reference model, no loss or duplication. Outputs hold stable while stalled, and in_ready=0 whenever out_valid && !out_ready.
- Reset mid-stream.
  - Stimulus: assert rst=0 for one cycle with 3 transactions in flight.
  - Required: out_valid=0 on the next cycle and none of the 3 results ever appear. A new transaction after reset releases appears STAGES cycles after its acceptance.
